// File: rtl/game_status_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : game_status_pkg                                              |
// | Brief    : Shared state encoding for the brick-breaker round tracker.   |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package game_status_pkg;

    localparam int GAME_STATE_W = 2;

    typedef enum logic [GAME_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } game_state_e;

endpackage : game_status_pkg

`default_nettype wire

// File: rtl/game_status_tracker_if.sv
// ---------------------------------------------------------------------------
// | Module   : game_status_tracker_if                                       |
// | Brief    : Game-event inputs and round-status outputs of the tracker.   |
// |            The score signal exists only when GAME_SCORE_EN is defined.  |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

interface game_status_tracker_if #(
    parameter int HEALTH_W = 10,
    parameter int LIVES_W  = 2
`ifdef GAME_SCORE_EN
    ,
    parameter int SCORE_W  = 16
`endif
);

    logic                start;
    logic [HEALTH_W-1:0] total_health;
    logic                brick_hit;
    logic                ball_lost;
    logic                playing;
    logic                win_occurred;
    logic                lose_occurred;
    logic                game_over_pulse;
    logic [HEALTH_W-1:0] health_left;
    logic [LIVES_W-1:0]  lives_left;
`ifdef GAME_SCORE_EN
    logic [SCORE_W-1:0]  score;
`endif

    modport master (
        output start, total_health, brick_hit, ball_lost,
        input  playing, win_occurred, lose_occurred, game_over_pulse,
        input  health_left, lives_left
`ifdef GAME_SCORE_EN
        ,
        input  score
`endif
    );

    modport slave (
        input  start, total_health, brick_hit, ball_lost,
        output playing, win_occurred, lose_occurred, game_over_pulse,
        output health_left, lives_left
`ifdef GAME_SCORE_EN
        ,
        output score
`endif
    );

endinterface : game_status_tracker_if

`default_nettype wire

// File: rtl/game_down_counter.sv
// ---------------------------------------------------------------------------
// | Module   : game_down_counter                                            |
// | Brief    : Loadable down counter that stops at zero, with zero and      |
// |            at-one flags.                                                |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module game_down_counter #(
    parameter int W = 4
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    input  wire logic         load_i,
    input  wire logic [W-1:0] load_val_i,
    input  wire logic         dec_i,
    output logic      [W-1:0] count_o,
    output logic              zero_o,
    output logic              at_one_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign zero_o   = (count_q == '0);
    assign at_one_o = (count_q == W'(1));

endmodule : game_down_counter

`default_nettype wire

// File: rtl/game_status_tracker.sv
// ---------------------------------------------------------------------------
// | Module   : game_status_tracker                                          |
// | Brief    : Tracks one brick-breaker round: health, lives, win/lose.     |
// |            Define GAME_SCORE_EN to add the saturating score output.     |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module game_status_tracker
    import game_status_pkg::*;
#(
    parameter int HEALTH_W       = 10,
    parameter int LIVES          = 3,
    parameter int LIVES_W        = 2
`ifdef GAME_SCORE_EN
    ,
    parameter int SCORE_W        = 16,
    parameter int POINTS_PER_HIT = 10
`endif
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    game_status_tracker_if.slave  bus
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    game_state_e         state_q;
    logic                playing_q;
    logic                win_q;
    logic                lose_q;
    logic                pulse_q;

    logic [HEALTH_W-1:0] w_health;
    logic                w_health_zero;
    logic                w_health_one;
    logic [LIVES_W-1:0]  w_lives;
    logic                w_lives_zero;
    logic                w_lives_one;

    logic                w_in_play;
    logic                w_th_zero;
    logic                w_hit_acc;
    logic                w_final_hit;
    logic                w_lose_acc;
    logic                w_final_loss;

    // start masks every other event; a round-ending hit masks a same-cycle ball loss.
    assign w_in_play    = (state_q == ST_PLAY);
    assign w_th_zero    = (bus.total_health == '0);
    assign w_hit_acc    = !bus.start && w_in_play && bus.brick_hit && !w_health_zero;
    assign w_final_hit  = w_hit_acc && w_health_one;
    assign w_lose_acc   = !bus.start && w_in_play && bus.ball_lost && !w_final_hit
                          && !w_lives_zero;
    assign w_final_loss = w_lose_acc && w_lives_one;

    game_down_counter #(
        .W (HEALTH_W)
    ) u_health (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (bus.start),
        .load_val_i (bus.total_health),
        .dec_i      (w_hit_acc),
        .count_o    (w_health),
        .zero_o     (w_health_zero),
        .at_one_o   (w_health_one)
    );

    game_down_counter #(
        .W (LIVES_W)
    ) u_lives (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (bus.start),
        .load_val_i (LIVES_INIT),
        .dec_i      (w_lose_acc),
        .count_o    (w_lives),
        .zero_o     (w_lives_zero),
        .at_one_o   (w_lives_one)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            playing_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.start) begin
                state_q   <= w_th_zero ? ST_WIN : ST_PLAY;
                playing_q <= !w_th_zero;
                win_q     <= w_th_zero;
                lose_q    <= 1'b0;
                pulse_q   <= w_th_zero;
            end else if (w_final_hit) begin
                state_q   <= ST_WIN;
                playing_q <= 1'b0;
                win_q     <= 1'b1;
                pulse_q   <= 1'b1;
            end else if (w_final_loss) begin
                state_q   <= ST_LOSE;
                playing_q <= 1'b0;
                lose_q    <= 1'b1;
                pulse_q   <= 1'b1;
            end
        end
    end

`ifdef GAME_SCORE_EN
    localparam logic [SCORE_W:0] POINTS_EXT = (SCORE_W+1)'(POINTS_PER_HIT);

    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W:0]   w_score_sum;

    // One extra bit catches the carry so the score clamps at all-ones.
    assign w_score_sum = {1'b0, score_q} + POINTS_EXT;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            score_q <= '0;
        end else if (bus.start) begin
            score_q <= '0;
        end else if (w_hit_acc) begin
            score_q <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
        end
    end

    assign bus.score = score_q;
`endif

    assign bus.playing         = playing_q;
    assign bus.win_occurred    = win_q;
    assign bus.lose_occurred   = lose_q;
    assign bus.game_over_pulse = pulse_q;
    assign bus.health_left     = w_health;
    assign bus.lives_left      = w_lives;

endmodule : game_status_tracker

`default_nettype wire
